// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 single-precision divider (restoring, 26 quotient bits)
// Optional: define FPDIV_ROUND_NEAREST_EN for round-to-nearest-even; default truncates.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q
);

  typedef enum logic [2:0] {IDLE, PREP, DIV, NORM, DONE} state_t;

`ifdef FPDIV_ROUND_NEAREST_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  state_t             state;
  logic [31:0]        ra, rb;
  logic [23:0]        dvs;
  logic [24:0]        rem;
  logic [25:0]        quo;
  logic [4:0]         cnt;
  logic signed [9:0]  exp_r;
  logic               sgn;

  // One restoring step: compare, conditionally subtract, shift left.
  function automatic logic [25:0] div_step(input logic [24:0] r, input logic [23:0] d);
    logic        ge;
    logic [23:0] diff;
    ge   = r >= {1'b0, d};
    diff = ge ? 24'(r - {1'b0, d}) : r[23:0];
    return {ge, diff, 1'b0};
  endfunction

  // Operand classification, denormals flushed to zero
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, res_sgn;
  logic        special;
  logic [31:0] spec_q;

  assign ea      = ra[30:23];
  assign eb      = rb[30:23];
  assign a_zero  = (ea == 8'h00);
  assign b_zero  = (eb == 8'h00);
  assign a_inf   = (ea == 8'hFF) && (ra[22:0] == 23'd0);
  assign b_inf   = (eb == 8'hFF) && (rb[22:0] == 23'd0);
  assign a_nan   = (ea == 8'hFF) && (ra[22:0] != 23'd0);
  assign b_nan   = (eb == 8'hFF) && (rb[22:0] != 23'd0);
  assign res_sgn = ra[31] ^ rb[31];

  always_comb begin
    special = 1'b1;
    spec_q  = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_q = 32'hFFFF_FFFF;
    else if (a_inf || b_zero)
      spec_q = {res_sgn, 8'hFF, 23'd0};
    else if (a_zero || b_inf)
      spec_q = {res_sgn, 31'd0};
    else
      special = 1'b0;
  end

  // PREP performs the first division step so DIV needs only 25 cycles.
  logic [24:0] step_r;
  logic [23:0] step_d;
  logic [25:0] step;

  assign step_r = (state == PREP) ? {2'b01, ra[22:0]} : rem;
  assign step_d = (state == PREP) ? {1'b1, rb[22:0]} : dvs;
  assign step   = div_step(step_r, step_d);

  // Normalization, rounding and range checks
  logic               hi, guard, sticky, inc;
  logic [22:0]        mant, mant_f;
  logic [23:0]        mant_r;
  logic signed [9:0]  exp_adj, exp_f;
  logic [31:0]        norm_q;

  assign hi      = quo[25];
  assign mant    = hi ? quo[24:2] : quo[23:1];
  assign guard   = hi ? quo[1] : quo[0];
  assign sticky  = (hi & quo[0]) | (rem != 25'd0);
  assign exp_adj = hi ? exp_r : exp_r - 10'sd1;
  assign inc     = RNE & guard & (sticky | mant[0]);
  assign mant_r  = {1'b0, mant} + {23'd0, inc};
  assign exp_f   = mant_r[23] ? exp_adj + 10'sd1 : exp_adj;
  assign mant_f  = mant_r[23] ? 23'd0 : mant_r[22:0];

  always_comb begin
    norm_q = {sgn, exp_f[7:0], mant_f};
    if (exp_f >= 10'sd255)
      norm_q = {sgn, 8'hFF, 23'd0};
    else if (exp_f <= 10'sd0)
      norm_q = {sgn, 31'd0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= 32'd0;
      ra    <= 32'd0;
      rb    <= 32'd0;
      dvs   <= 24'd0;
      rem   <= 25'd0;
      quo   <= 26'd0;
      cnt   <= 5'd0;
      exp_r <= 10'sd0;
      sgn   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          sgn <= res_sgn;
          if (special) begin
            q     <= spec_q;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dvs   <= {1'b1, rb[22:0]};
            rem   <= step[24:0];
            quo   <= {25'd0, step[25]};
            cnt   <= 5'd1;
            exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            state <= DIV;
          end
        end
        DIV: begin
          rem <= step[24:0];
          quo <= {quo[24:0], step[25]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd25)
            state <= NORM;
        end
        NORM: begin
          q     <= norm_q;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
